act_bwd: RTL and testbench

ACT_BWD -- requirements
Module: act_bwd

---
 rtl/act_pkg.sv | 19 +
 rtl/act_bwd_cmp.sv | 25 ++
 rtl/act_bwd.sv | 114 +++++++++++
 tb/tb_act_bwd.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared definitions for the activation backward-pass block.
package act_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned FRAC_DEF  = 0;
  localparam int unsigned CNT_W_DEF = 16;

  // Region of x relative to the +/-ONE knees of f(x).
  typedef enum logic [1:0] {
    POS  = 2'd0,
    NEG  = 2'd1,
    ZERO = 2'd2
  } sel_e;

  // Saturation limits at the default width.
  localparam logic signed [WIDTH_DEF-1:0] MAX_POS = {1'b0, {(WIDTH_DEF-1){1'b1}}};
  localparam logic signed [WIDTH_DEF-1:0] MIN_NEG = {1'b1, {(WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/act_bwd_cmp.sv
// Classifies the forward pre-activation x against +/-ONE using full-width signed compares.
module act_bwd_cmp
  import act_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned FRAC  = FRAC_DEF
) (
  input  logic signed [2*WIDTH-1:0] x,
  output sel_e                      sel
);

  localparam logic signed [2*WIDTH-1:0] ONE =
    $signed({{(2*WIDTH-1){1'b0}}, 1'b1} << FRAC);
  localparam logic signed [2*WIDTH-1:0] NEG_ONE = -ONE;

  always_comb begin
    sel = ZERO;
    if (x > ONE) begin
      sel = POS;
    end else if (x < NEG_ONE) begin
      sel = NEG;
    end
  end

endmodule

// File: rtl/act_bwd.sv
// Two-stage backward pass of f(x)=(|x+ONE|+|x-ONE|)>>>1 with valid/ready handshake and
// per-frame element counting.
module act_bwd
  import act_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned FRAC  = FRAC_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [2*WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0]   in_delta,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH-1:0]   out_grad,
  output logic                      out_last,
  output logic [CNT_W-1:0]          elem_cnt,
  output logic                      frame_done
);

  localparam logic signed [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic                    en;
  logic                    accept;
  logic                    xfer;
  sel_e                    x_sel;

  logic                    s1_valid;
  sel_e                    s1_sel;
  logic signed [WIDTH-1:0] s1_delta;
  logic                    s1_last;

  logic signed [WIDTH-1:0] neg_delta;
  logic signed [WIDTH-1:0] grad_d;

  // Whole pipeline advances together; a stalled output freezes both stages.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign xfer     = out_valid && out_ready;

  act_bwd_cmp #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_cmp (
    .x   (in_x),
    .sel (x_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sel   <= ZERO;
      s1_delta <= '0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_sel   <= x_sel;
        s1_delta <= in_delta;
        s1_last  <= in_last;
      end
    end
  end

  // -MIN is not representable, so it clamps to MAX.
  always_comb begin
    neg_delta = -s1_delta;
    if (s1_delta == SAT_NEG) begin
      neg_delta = SAT_POS;
    end
  end

  always_comb begin
    grad_d = '0;
    unique case (s1_sel)
      POS:     grad_d = s1_delta;
      NEG:     grad_d = neg_delta;
      default: grad_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_grad  <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_grad <= grad_d;
        out_last <= s1_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= xfer && out_last;
      if (xfer) begin
        elem_cnt <= out_last ? '0 : elem_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_act_bwd.sv
// Directed self-checking bench for act_bwd (FRAC=0 and FRAC=8 instances).
module tb_act_bwd;

  logic               clk = 1'b0;
  logic               rst = 1'b1;

  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_x = '0;
  logic signed [15:0] in_delta = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_grad;
  logic               out_last;
  logic [15:0]        elem_cnt;
  logic               frame_done;

  logic               f_in_valid = 1'b0;
  logic               f_in_ready;
  logic signed [31:0] f_in_x = '0;
  logic signed [15:0] f_in_delta = '0;
  logic               f_out_valid;
  logic signed [15:0] f_out_grad;
  logic               f_out_last;
  logic [15:0]        f_elem_cnt;
  logic               f_frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  act_bwd #(.WIDTH(16), .FRAC(0), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_delta   (in_delta),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_grad   (out_grad),
    .out_last   (out_last),
    .elem_cnt   (elem_cnt),
    .frame_done (frame_done)
  );

  act_bwd #(.WIDTH(16), .FRAC(8), .CNT_W(16)) u_dut_frac (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (f_in_valid),
    .in_ready   (f_in_ready),
    .in_x       (f_in_x),
    .in_delta   (f_in_delta),
    .in_last    (1'b0),
    .out_valid  (f_out_valid),
    .out_ready  (1'b1),
    .out_grad   (f_out_grad),
    .out_last   (f_out_last),
    .elem_cnt   (f_elem_cnt),
    .frame_done (f_frame_done)
  );

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_grad !== 16'sd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: valid=%b grad=%0d last=%b want 0/0/0", out_valid, out_grad, out_last);
    end
    checks++;
    if (elem_cnt !== 16'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt: cnt=%0d done=%b want 0/0", elem_cnt, frame_done);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  // Sign select and saturation, each beat checked for two-cycle latency.
  task automatic test_sign_select();
    int xs[6] = '{5, -5, 1, -1, -3, 3};
    int ds[6] = '{100, 100, 100, 100, -32768, -32768};
    int es[6] = '{100, -100, 0, 0, 32767, -32768};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_x     = 32'(xs[i]);
      in_delta = 16'(ds[i]);
      in_last  = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL sel_ready[%0d]: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sel_early[%0d]: out_valid=%b want 0", i, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_grad !== 16'(es[i])) begin
        errors++;
        $display("FAIL sel_grad[%0d]: valid=%b grad=%0d want 1/%0d", i, out_valid, out_grad,
                 es[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int xs[8] = '{10, -10, 0, 20, -20, 1, -1, 30};
    int ds[8] = '{11, 12, 13, 14, 15, 16, 17, 18};
    int es[8] = '{11, -12, 0, 14, -15, 0, 0, 18};
    int sent = 0;
    int rcvd = 0;
    do_reset();
    for (int t = 0; t < 40 && rcvd < 8; t++) begin
      @(posedge clk); #1;
      out_ready = !(t >= 3 && t <= 5);
      #1;
      if (t >= 3 && t <= 5) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_grad !== 16'(es[rcvd])) begin
          errors++;
          $display("FAIL stall_hold t=%0d: ready=%b valid=%b grad=%0d want 0/1/%0d", t,
                   in_ready, out_valid, out_grad, es[rcvd]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_grad !== 16'(es[rcvd])) begin
          errors++;
          $display("FAIL stream[%0d]: got %0d want %0d", rcvd, out_grad, es[rcvd]);
        end
        rcvd++;
      end
      if (sent < 8) begin
        in_valid = 1'b1;
        in_x     = 32'(xs[sent]);
        in_delta = 16'(ds[sent]);
        in_last  = 1'b0;
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rcvd != 8) begin
      errors++;
      $display("FAIL stream_count: got %0d want 8", rcvd);
    end
  endtask

  task automatic test_frame();
    int exp_cnt[8]  = '{0, 0, 0, 1, 2, 3, 0, 0};
    int exp_done[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    do_reset();
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      in_valid = (t < 4);
      in_x     = 32'(t + 2);
      in_delta = 16'(t + 1);
      in_last  = (t == 3);
      checks++;
      if (elem_cnt !== 16'(exp_cnt[t]) || frame_done !== 1'(exp_done[t])) begin
        errors++;
        $display("FAIL frame t=%0d: cnt=%0d done=%b want %0d/%0d", t, elem_cnt, frame_done,
                 exp_cnt[t], exp_done[t]);
      end
      if (t == 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || out_grad !== 16'sd4) begin
          errors++;
          $display("FAIL frame_last: valid=%b last=%b grad=%0d want 1/1/4", out_valid, out_last,
                   out_grad);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit saw_done = 0;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_x     = 32'sd9;
      in_delta = 16'sd50;
      in_last  = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (elem_cnt !== 16'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: cnt=%0d valid=%b want 1/1", elem_cnt, out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || elem_cnt !== 16'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: valid=%b cnt=%0d done=%b want 0/0/0", out_valid, elem_cnt,
               frame_done);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      if (frame_done || out_valid) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL mid_flush: stale output or frame_done after reset, want none");
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_x     = -32'sd9;
    in_delta = 16'sd21;
    in_last  = 1'b0;
    @(posedge clk); #1;
    in_last  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_grad !== -16'sd21 || elem_cnt !== 16'd0) begin
      errors++;
      $display("FAIL new_frame0: valid=%b grad=%0d cnt=%0d want 1/-21/0", out_valid, out_grad,
               elem_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (elem_cnt !== 16'd1 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL new_frame1: cnt=%0d last=%b want 1/1", elem_cnt, out_last);
    end
    @(posedge clk); #1;
    checks++;
    if (elem_cnt !== 16'd0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL new_frame_done: cnt=%0d done=%b want 0/1", elem_cnt, frame_done);
    end
  endtask

  task automatic test_frac8();
    int xs[5] = '{256, 257, 32'sh8000_0000, -256, -257};
    int ds[5] = '{5, 7, 9, 3, 4};
    int es[5] = '{0, 7, -9, 0, -4};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      f_in_valid = 1'b1;
      f_in_x     = 32'(xs[i]);
      f_in_delta = 16'(ds[i]);
      @(posedge clk); #1;
      f_in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (f_out_valid !== 1'b1 || f_out_grad !== 16'(es[i])) begin
        errors++;
        $display("FAIL frac8[%0d]: valid=%b grad=%0d want 1/%0d", i, f_out_valid, f_out_grad,
                 es[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sign_select();
    test_back_to_back();
    test_frame();
    test_reset_mid_frame();
    test_frac8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
